// File: rtl/instruction_memory_responder_pkg.sv
// Shared types and constants for the instruction-fetch responder: instruction and
// address types, default backing-memory latency and requester-index width helper.
package instruction_memory_responder_pkg;

    localparam int INSTRUCTION_WIDTH    = 32;
    localparam int IMEM_ADDRESS_WIDTH   = 16;
    localparam int IMEM_DEFAULT_LATENCY = 1;

    typedef logic [INSTRUCTION_WIDTH-1:0]  instruction_t;
    typedef logic [IMEM_ADDRESS_WIDTH-1:0] instruction_memory_address_t;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int requester_index_width(input int num_requesters);
        return (num_requesters > 1) ? $clog2(num_requesters) : 1;
    endfunction

endpackage

// File: rtl/instruction_memory_responder_if.sv
// Fetch-side (fetchers <-> responder) and memory-side (responder <-> instruction
// BRAM/ROM) bundles. The fetchers and the responder are master on their own side.
interface imem_fetch_if #(
    parameter int NUM_REQUESTERS = 4
);
    import instruction_memory_responder_pkg::*;

    logic [NUM_REQUESTERS-1:0]                        read_valid;
    instruction_memory_address_t [NUM_REQUESTERS-1:0] read_address;
    logic [NUM_REQUESTERS-1:0]                        read_ready;
    instruction_t [NUM_REQUESTERS-1:0]                read_data;

    modport master (output read_valid, read_address, input read_ready, read_data);
    modport slave  (input read_valid, read_address, output read_ready, read_data);
endinterface

interface imem_mem_if;
    import instruction_memory_responder_pkg::*;

    logic                        mem_read_en;
    instruction_memory_address_t mem_read_address;
    instruction_t                mem_read_data;

    modport master (output mem_read_en, mem_read_address, input mem_read_data);
    modport slave  (input mem_read_en, mem_read_address, output mem_read_data);
endinterface

// File: rtl/instruction_memory_responder_imem_arbiter.sv
// Picks at most one eligible requester per cycle. With IMEM_ROUND_ROBIN_EN the search
// starts one past the last grant; otherwise the lowest eligible index wins.
module imem_arbiter
    import instruction_memory_responder_pkg::*;
#(
    parameter int  NUM_REQUESTERS = 4,
    localparam int IDX_W          = requester_index_width(NUM_REQUESTERS)
) (
`ifdef IMEM_ROUND_ROBIN_EN
    input  logic                      clk,
    input  logic                      reset_n,
`endif
    input  logic [NUM_REQUESTERS-1:0] eligible_i,
    output logic [NUM_REQUESTERS-1:0] grant_o,
    output logic [IDX_W-1:0]          grant_idx_o,
    output logic                      grant_valid_o
);

`ifdef IMEM_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;
`endif

    // NOTE: every variable written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        int idx;
        idx           = 0;
        grant_o       = '0;
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        for (int k = 0; k < NUM_REQUESTERS; k++) begin
`ifdef IMEM_ROUND_ROBIN_EN
            idx = (int'(ptr_q) + k) % NUM_REQUESTERS;
`else
            idx = k;
`endif
            if (!grant_valid_o && eligible_i[idx]) begin
                grant_valid_o = 1'b1;
                grant_o[idx]  = 1'b1;
                grant_idx_o   = IDX_W'(idx);
            end
        end
    end

`ifdef IMEM_ROUND_ROBIN_EN
    always_comb begin
        ptr_d = ptr_q;
        if (grant_valid_o) begin
            ptr_d = (int'(grant_idx_o) == NUM_REQUESTERS - 1) ? '0 : grant_idx_o + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

endmodule

// File: rtl/instruction_memory_responder.sv
// Instruction-fetch responder: arbitrates per-warp fetch requests onto a fixed-latency
// instruction memory and returns data with a one-cycle ready. Option: IMEM_ROUND_ROBIN_EN.
module instruction_memory_responder
    import instruction_memory_responder_pkg::*;
#(
    parameter int NUM_REQUESTERS = 4,
    parameter int MEM_LATENCY    = IMEM_DEFAULT_LATENCY
) (
    input logic         clk,
    input logic         reset_n,
    imem_fetch_if.slave fetch_bus,
    imem_mem_if.master  mem_bus
);

    localparam int IDX_W = requester_index_width(NUM_REQUESTERS);

    logic [NUM_REQUESTERS-1:0]         pending_q, pending_d;
    logic [NUM_REQUESTERS-1:0]         ready_q, ready_d;
    instruction_t [NUM_REQUESTERS-1:0] data_q, data_d;
    logic                              mem_en_q, mem_en_d;
    instruction_memory_address_t       mem_addr_q, mem_addr_d;
    logic [IDX_W-1:0]                  issue_idx_q, issue_idx_d;
    logic [MEM_LATENCY-1:0]            tag_valid_q, tag_valid_d;
    logic [MEM_LATENCY-1:0][IDX_W-1:0] tag_idx_q, tag_idx_d;

    logic [NUM_REQUESTERS-1:0] eligible;
    logic [NUM_REQUESTERS-1:0] grant;
    logic [IDX_W-1:0]          grant_idx;
    logic                      grant_valid;

    // A fetcher being acked still shows valid at the ack edge; masking on ready_q stops a re-grant.
    assign eligible = fetch_bus.read_valid & ~pending_q & ~ready_q;

    imem_arbiter #(
        .NUM_REQUESTERS(NUM_REQUESTERS)
    ) u_arbiter (
`ifdef IMEM_ROUND_ROBIN_EN
        .clk          (clk),
        .reset_n      (reset_n),
`endif
        .eligible_i   (eligible),
        .grant_o      (grant),
        .grant_idx_o  (grant_idx),
        .grant_valid_o(grant_valid)
    );

    always_comb begin
        pending_d   = pending_q;
        ready_d     = '0;
        data_d      = data_q;
        mem_en_d    = grant_valid;
        mem_addr_d  = mem_addr_q;
        issue_idx_d = issue_idx_q;

        // The tag of the issued read trails mem_en_q so the last stage lines up with mem_read_data.
        tag_valid_d[0] = mem_en_q;
        tag_idx_d[0]   = issue_idx_q;
        for (int s = 1; s < MEM_LATENCY; s++) begin
            tag_valid_d[s] = tag_valid_q[s-1];
            tag_idx_d[s]   = tag_idx_q[s-1];
        end

        if (tag_valid_q[MEM_LATENCY-1]) begin
            ready_d[tag_idx_q[MEM_LATENCY-1]]   = 1'b1;
            data_d[tag_idx_q[MEM_LATENCY-1]]    = mem_bus.mem_read_data;
            pending_d[tag_idx_q[MEM_LATENCY-1]] = 1'b0;
        end

        if (grant_valid) begin
            mem_addr_d  = fetch_bus.read_address[grant_idx];
            issue_idx_d = grant_idx;
            pending_d   = pending_d | grant;
        end
    end

    // NOTE: the returned-data registers are reset too, because every output must read 0 in reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q   <= '0;
            ready_q     <= '0;
            data_q      <= '0;
            mem_en_q    <= 1'b0;
            mem_addr_q  <= '0;
            issue_idx_q <= '0;
            tag_valid_q <= '0;
            tag_idx_q   <= '0;
        end else begin
            pending_q   <= pending_d;
            ready_q     <= ready_d;
            data_q      <= data_d;
            mem_en_q    <= mem_en_d;
            mem_addr_q  <= mem_addr_d;
            issue_idx_q <= issue_idx_d;
            tag_valid_q <= tag_valid_d;
            tag_idx_q   <= tag_idx_d;
        end
    end

    assign fetch_bus.read_ready     = ready_q;
    assign fetch_bus.read_data      = data_q;
    assign mem_bus.mem_read_en      = mem_en_q;
    assign mem_bus.mem_read_address = mem_addr_q;

endmodule

// File: tb/tb_instruction_memory_responder.sv
// Scoreboard bench: two responders (latency 1 and 3) against behavioural memories;
// expected words are queued per lane on request and popped on each read_ready.
module tb_instruction_memory_responder;
    import instruction_memory_responder_pkg::*;

    localparam int N = 4;

    typedef struct {
        int cyc;
        int val;
    } ev_t;

    logic clk = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    imem_fetch_if #(.NUM_REQUESTERS(N)) f1 ();
    imem_mem_if                         m1 ();
    imem_fetch_if #(.NUM_REQUESTERS(N)) f3 ();
    imem_mem_if                         m3 ();

    instruction_memory_responder #(.NUM_REQUESTERS(N), .MEM_LATENCY(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .fetch_bus(f1.slave), .mem_bus(m1.master));
    instruction_memory_responder #(.NUM_REQUESTERS(N), .MEM_LATENCY(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .fetch_bus(f3.slave), .mem_bus(m3.master));

    logic                        v1[N];
    logic                        v3[N];
    instruction_memory_address_t a1[N];
    instruction_memory_address_t a3[N];

    for (genvar g = 0; g < N; g++) begin : g_drive
        assign f1.read_valid[g]   = v1[g];
        assign f1.read_address[g] = a1[g];
        assign f3.read_valid[g]   = v3[g];
        assign f3.read_address[g] = a3[g];
    end

    function automatic instruction_t mem_word(input instruction_memory_address_t a);
        return (a == 16'h0010) ? 32'hDEAD_BEEF : {a ^ 16'hC3A5, a};
    endfunction

    // Behavioural memories: data valid exactly MEM_LATENCY cycles after the strobe cycle.
    instruction_t pipe1;
    instruction_t pipe3[3];
    always @(posedge clk) begin
        pipe1    <= m1.mem_read_en ? mem_word(m1.mem_read_address) : 32'hBAD0_0001;
        pipe3[0] <= m3.mem_read_en ? mem_word(m3.mem_read_address) : 32'hBAD0_0003;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign m1.mem_read_data = pipe1;
    assign m3.mem_read_data = pipe3[2];

    instruction_t exp1_q[N][$];
    instruction_t exp3_q[N][$];
    ev_t          grant_log1[$];
    ev_t          ready_log1[$];
    ev_t          ready_log3[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_events(input string tag, input ev_t log_q[$], input int t0,
                                input int exp_cyc[$], input int exp_val[$]);
        check({tag, "_count"}, 64'(log_q.size()), 64'(exp_cyc.size()));
        for (int i = 0; i < exp_cyc.size() && i < log_q.size(); i++) begin
            check($sformatf("%s_cycle%0d", tag, i), 64'(log_q[i].cyc - t0), 64'(exp_cyc[i]));
            check($sformatf("%s_lane%0d", tag, i), 64'(log_q[i].val), 64'(exp_val[i]));
        end
    endtask

    // Latency-1 monitor: grant bookkeeping, per-lane scoreboard and hold-between-acks checks.
    initial begin
        int           outstanding[N];
        instruction_t last_data[N];
        int           lane;
        for (int k = 0; k < N; k++) begin
            outstanding[k] = 0;
            last_data[k]   = '0;
        end
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                for (int k = 0; k < N; k++) begin
                    outstanding[k] = 0;
                    last_data[k]   = '0;
                end
            end else begin
                if (m1.mem_read_en) begin
                    lane = -1;
                    for (int k = 0; k < N; k++)
                        if (v1[k] && a1[k] == m1.mem_read_address) lane = k;
                    grant_log1.push_back('{cyc, lane});
                    check("grant_lane_found", 64'(lane >= 0), 64'd1);
                    if (lane >= 0) begin
                        check($sformatf("no_double_grant%0d", lane), 64'(outstanding[lane]), 64'd0);
                        outstanding[lane]++;
                    end
                end
                for (int k = 0; k < N; k++) begin
                    if (f1.read_ready[k]) begin
                        ready_log1.push_back('{cyc, k});
                        check($sformatf("ready_expected%0d", k), 64'(exp1_q[k].size() > 0), 64'd1);
                        if (exp1_q[k].size() > 0)
                            check($sformatf("data%0d", k), 64'(f1.read_data[k]), 64'(exp1_q[k].pop_front()));
                        if (outstanding[k] > 0) outstanding[k]--;
                        last_data[k] = f1.read_data[k];
                    end else begin
                        check($sformatf("hold%0d", k), 64'(f1.read_data[k]), 64'(last_data[k]));
                    end
                end
            end
        end
    end

    // Latency-3 monitor: ready timing and data against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                for (int k = 0; k < N; k++) begin
                    if (f3.read_ready[k]) begin
                        ready_log3.push_back('{cyc, k});
                        check($sformatf("l3_ready_expected%0d", k), 64'(exp3_q[k].size() > 0), 64'd1);
                        if (exp3_q[k].size() > 0)
                            check($sformatf("l3_data%0d", k), 64'(f3.read_data[k]), 64'(exp3_q[k].pop_front()));
                    end
                end
            end
        end
    end

    // Call just after a rising edge; returns just after the edge that follows the ack.
    task automatic fetch(input bit slow, input int lane, input instruction_memory_address_t addr);
        int   waited;
        logic rdy;
        waited = 0;
        rdy    = 1'b0;
        if (slow) begin
            v3[lane] = 1'b1;
            a3[lane] = addr;
            exp3_q[lane].push_back(mem_word(addr));
        end else begin
            v1[lane] = 1'b1;
            a1[lane] = addr;
            exp1_q[lane].push_back(mem_word(addr));
        end
        do begin
            @(negedge clk);
            waited++;
            rdy = slow ? f3.read_ready[lane] : f1.read_ready[lane];
        end while (!rdy && waited < 20);
        check($sformatf("ack_seen_%0d_lane%0d", slow, lane), 64'(rdy), 64'd1);
        @(posedge clk);
        #1;
        if (slow) v3[lane] = 1'b0;
        else      v1[lane] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        grant_log1.delete();
        ready_log1.delete();
        ready_log3.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int ec[$];
        int ev[$];
        reset_n = 1'b0;
        for (int k = 0; k < N; k++) begin
            v1[k] = 1'b0; v3[k] = 1'b0; a1[k] = '0; a3[k] = '0;
        end
        idle(3);
        check("reset_mem_en",    64'(m1.mem_read_en), 64'd0);
        check("reset_mem_addr",  64'(m1.mem_read_address), 64'd0);
        check("reset_ready",     64'(f1.read_ready), 64'd0);
        check("reset_data",      64'(f1.read_data), 64'd0);
        reset_n = 1'b1;
        idle(2);

        // Single request: strobe in cycle 1, ack in cycle 3, valid held through the ack edge.
        clear_logs();
        t0 = cyc;
        fetch(1'b0, 0, 16'h0010);
        idle(4);
        ec = '{1}; ev = '{0};
        check_events("single_grant", grant_log1, t0, ec, ev);
        ec = '{3}; ev = '{0};
        check_events("single_ready", ready_log1, t0, ec, ev);
        check("single_data_word", 64'(f1.read_data[0]), 64'hDEAD_BEEF);

        // All four at once: one grant per cycle in index order, acks in cycles 3..6.
        clear_logs();
        t0 = cyc;
        fork
            fetch(1'b0, 0, 16'h0000);
            fetch(1'b0, 1, 16'h0001);
            fetch(1'b0, 2, 16'h0002);
            fetch(1'b0, 3, 16'h0003);
        join
        idle(3);
        ec = '{1, 2, 3, 4}; ev = '{0, 1, 2, 3};
        check_events("all4_grant", grant_log1, t0, ec, ev);
        ec = '{3, 4, 5, 6}; ev = '{0, 1, 2, 3};
        check_events("all4_ready", ready_log1, t0, ec, ev);

        // Fetcher 0 re-requests right after each ack while 3 waits: 3 slips in while 0 is pending.
        clear_logs();
        t0 = cyc;
        fork
            begin
                fetch(1'b0, 0, 16'h0020);
                fetch(1'b0, 0, 16'h0024);
                fetch(1'b0, 0, 16'h0028);
            end
            fetch(1'b0, 3, 16'h0033);
        join
        idle(3);
        ec = '{1, 2, 5, 9}; ev = '{0, 3, 0, 0};
        check_events("busy_grant", grant_log1, t0, ec, ev);
        ec = '{3, 4, 7, 11}; ev = '{0, 3, 0, 0};
        check_events("busy_ready", ready_log1, t0, ec, ev);

        // Latency 3, back-to-back fetchers 0 and 1: acks in cycles 5 and 6, in order.
        clear_logs();
        t0 = cyc;
        fork
            fetch(1'b1, 0, 16'h0100);
            fetch(1'b1, 1, 16'h0101);
        join
        idle(3);
        ec = '{5, 6}; ev = '{0, 1};
        check_events("lat3_ready", ready_log3, t0, ec, ev);

        // One-cycle reset with two reads in flight: outputs clear and the reads never ack.
        clear_logs();
        v1[1] = 1'b1; a1[1] = 16'h0051; exp1_q[1].push_back(mem_word(16'h0051));
        v1[2] = 1'b1; a1[2] = 16'h0062; exp1_q[2].push_back(mem_word(16'h0062));
        idle(2);
        v1[1] = 1'b0; v1[2] = 1'b0;
        reset_n = 1'b0;
        #1;
        check("rst_mem_en",   64'(m1.mem_read_en), 64'd0);
        check("rst_mem_addr", 64'(m1.mem_read_address), 64'd0);
        check("rst_ready",    64'(f1.read_ready), 64'd0);
        check("rst_data",     64'(f1.read_data), 64'd0);
        for (int k = 0; k < N; k++) exp1_q[k].delete();
        idle(1);
        reset_n = 1'b1;
        clear_logs();
        idle(6);
        check("rst_no_late_ready", 64'(ready_log1.size()), 64'd0);
        check("rst_no_late_grant", 64'(grant_log1.size()), 64'd0);

        // Fresh request after reset is served normally.
        clear_logs();
        t0 = cyc;
        fetch(1'b0, 1, 16'h0077);
        idle(2);
        ec = '{3}; ev = '{1};
        check_events("post_rst_ready", ready_log1, t0, ec, ev);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
